counter_sequencer: RTL and testbench

Programmable interval controller that sequences a free-running binary counter datapath into one-shot or periodic timed intervals.
- Accepts a configuration (period, prescale, mode) over a valid/ready handshake.
- Starts and stops the count on command and emits a single-cycle terminal tick.
- Sits between the control/LED logic and the counter datapath. It is the only block that enables, clears or wraps the counter.

---
 rtl/counter_sequencer.sv | 121 ++++++++++++
 tb/tb_counter_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// Interval controller: sequences a prescaled binary counter into one-shot or
// periodic intervals, emitting a single-cycle tick at the terminal count.
module counter_sequencer #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  neg_reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [WIDTH-1:0]      cfg_period,
    input  logic [PRESCALE_W-1:0] cfg_prescale,
    input  logic                  cfg_mode,
    input  logic                  start,
    input  logic                  stop,
    output logic [WIDTH-1:0]      count_out,
    output logic                  tick,
    output logic                  busy,
    output logic [1:0]            state_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic [PRESCALE_W-1:0] psc_q, psc_d;
    logic                  tick_q, tick_d;
    logic                  busy_q;
    logic [WIDTH-1:0]      period_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic                  mode_q;

    logic cfg_xfer;
    logic step;
    logic terminal;

    // Config is held off (not dropped) while an interval is running.
    assign cfg_ready = (state_q != RUN);
    assign cfg_xfer  = cfg_valid && cfg_ready;
    assign step      = (psc_q == prescale_q);
    assign terminal  = step && (count_q == period_q);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        psc_d   = psc_q;
        tick_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    count_d = '0;
                    psc_d   = '0;
                end
            end
            RUN: begin
                // Stop wins over a same-cycle terminal event, suppressing the tick.
                if (stop) begin
                    state_d = IDLE;
                    count_d = '0;
                    psc_d   = '0;
                end else begin
                    psc_d = step ? '0 : psc_q + 1'b1;
                    if (terminal) begin
                        count_d = '0;
                        tick_d  = 1'b1;
                        if (!mode_q) state_d = DONE;
                    end else if (step) begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            DONE: begin
                count_d = '0;
                psc_d   = '0;
                if (stop)       state_d = IDLE;
                else if (start) state_d = RUN;
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                psc_d   = '0;
            end
        endcase
    end

    // Config latched on the same edge as a start, so it governs that interval.
    always_ff @(posedge clk or negedge neg_reset) begin
        if (!neg_reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            psc_q      <= '0;
            tick_q     <= 1'b0;
            busy_q     <= 1'b0;
            period_q   <= '1;
            prescale_q <= '0;
            mode_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            psc_q   <= psc_d;
            tick_q  <= tick_d;
            busy_q  <= (state_d == RUN);
            if (cfg_xfer) begin
                period_q   <= cfg_period;
                prescale_q <= cfg_prescale;
                mode_q     <= cfg_mode;
            end
        end
    end

    assign count_out = count_q;
    assign tick      = tick_q;
    assign busy      = busy_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: an elapsed-clock interval model
// predicts each registered output cycle, queued at drive time and popped after the edge.
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       neg_reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_period;
    logic [3:0] cfg_prescale;
    logic       cfg_mode;
    logic       start;
    logic       stop;
    logic [7:0] count_out;
    logic       tick;
    logic       busy;
    logic [1:0] state_out;

    counter_sequencer #(.WIDTH(8), .PRESCALE_W(4)) dut (
        .clk          (clk),
        .neg_reset    (neg_reset),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_period   (cfg_period),
        .cfg_prescale (cfg_prescale),
        .cfg_mode     (cfg_mode),
        .start        (start),
        .stop         (stop),
        .count_out    (count_out),
        .tick         (tick),
        .busy         (busy),
        .state_out    (state_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int cnt;
        int tk;
        int bz;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_mis = 0;

    // Reference model: elapsed clocks within the current interval.
    int m_state, m_k, m_period, m_pre, m_mode;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_k      = 0;
        m_period = 255;
        m_pre    = 0;
        m_mode   = 0;
    endtask

    task automatic cycle();
        int   len;
        int   tk;
        exp_t e;
        exp_t got;
        chk("cfg_ready", int'(cfg_ready), (m_state != 1) ? 1 : 0);
        len = (m_period + 1) * (m_pre + 1);
        tk  = 0;
        case (m_state)
            0: if (start) begin m_state = 1; m_k = 0; end
            1: begin
                if (stop) begin
                    m_state = 0; m_k = 0;
                end else if (m_k == len - 1) begin
                    m_k = 0; tk = 1;
                    if (m_mode == 0) m_state = 2;
                end else begin
                    m_k++;
                end
            end
            default: begin
                m_k = 0;
                if (stop)       m_state = 0;
                else if (start) m_state = 1;
            end
        endcase
        if (cfg_valid && (m_state_prev_ready())) begin
            m_period = int'(cfg_period);
            m_pre    = int'(cfg_prescale);
            m_mode   = int'(cfg_mode);
        end
        e.st  = m_state;
        e.cnt = m_k / (m_pre + 1);
        e.tk  = tk;
        e.bz  = (m_state == 1) ? 1 : 0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk("state", int'(state_out), got.st);
        chk("count", int'(count_out), got.cnt);
        chk("tick",  int'(tick),      got.tk);
        chk("busy",  int'(busy),      got.bz);
    endtask

    // cfg_ready as seen before this edge; captured at drive time.
    logic ready_before;
    function automatic logic m_state_prev_ready();
        return ready_before;
    endfunction

    task automatic drive(input logic cv, input int per, input int pre, input logic md,
                         input logic st, input logic sp);
        cfg_valid    = cv;
        cfg_period   = per[7:0];
        cfg_prescale = pre[3:0];
        cfg_mode     = md;
        start        = st;
        stop         = sp;
        ready_before = (m_state != 1);
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, int'(state_out), 0);
        chk({tag, "_count"}, int'(count_out), 0);
        chk({tag, "_tick"},  int'(tick),      0);
        chk({tag, "_busy"},  int'(busy),      0);
        chk({tag, "_ready"}, int'(cfg_ready), 1);
    endtask

    initial begin
        neg_reset    = 1'b0;
        cfg_valid    = 1'b0;
        cfg_period   = '0;
        cfg_prescale = '0;
        cfg_mode     = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
        ready_before = 1'b1;
        model_reset();
        #2;
        check_reset_outputs("rst");
        @(posedge clk);
        @(posedge clk);
        #1 neg_reset = 1'b1;

        // 1: periodic period=3 prescale=0, config with start
        drive(1'b1, 3, 0, 1'b1, 1'b1, 1'b0);
        idle(14);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // 2: one-shot period=2 prescale=2, then a second identical run
        drive(1'b1, 2, 2, 1'b0, 1'b1, 1'b0);
        idle(11);
        drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        idle(11);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        idle(1);

        // 3: stop exactly when count shows the terminal value
        drive(1'b1, 3, 0, 1'b1, 1'b1, 1'b0);
        idle(3);
        chk("pre_stop_count", int'(count_out), 3);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // 4: config held during one-shot run lands once DONE
        drive(1'b1, 2, 0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 5, 0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        idle(8);

        // 5: period=0 prescale=1 periodic with start pulses mid-run
        drive(1'b1, 0, 1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) drive(1'b0, 0, 0, 1'b0, (i % 3) == 1, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);

        // period=0 prescale=0 periodic: tick every cycle
        drive(1'b1, 0, 0, 1'b1, 1'b1, 1'b0);
        idle(4);

        // 6: async reset between edges mid-run, then defaults
        #3 neg_reset = 1'b0;
        #1;
        check_reset_outputs("async");
        model_reset();
        #2 neg_reset = 1'b1;
        drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        idle(258);

        chk("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
